// File: rtl/spi_regbank_pkg.sv
// Shared definitions for the SPI register bank: FSM state encoding, R/W bit
// values and the frame length helper.
package spi_regbank_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_ADDR = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with level and
// single-cycle rise/fall indications on the synchronised value.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_regbank.sv
// Mode-0 SPI slave owning NUM_REGS registers: framed writes commit on chip-select
// release, reads stream the addressed register out on cipo.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam int AW1   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME);
  localparam logic [AW1-1:0]   REGS_LIM     = AW1'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));
  // Chip select resets to its inactive level so reset never looks like a frame start
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));

  assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall, ncs_fall};

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [FRAME-1:0]   shift_in;
  logic               overrun;
  logic [DATA_W-1:0]  out_sh;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  rd_data;

  logic              fr_rw;
  logic [ADDR_W-1:0] fr_addr;
  logic [DATA_W-1:0] fr_data;
  logic              fr_in_range;
  logic              frame_ok;
  logic              commit;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_rw;
  logic              ld_in_range;

  assign cnt_next    = bit_cnt + CNT_ONE;
  assign fr_rw       = shift_in[FRAME-1];
  assign fr_addr     = shift_in[DATA_W +: ADDR_W];
  assign fr_data     = shift_in[DATA_W-1:0];
  assign fr_in_range = {1'b0, fr_addr} < REGS_LIM;
  assign frame_ok    = (state != ST_IDLE) && (bit_cnt == CNT_FRAME) && !overrun;
  assign commit      = ncs_rise && frame_ok && (fr_rw == RW_WRITE) && fr_in_range;

  // While the address has just completed, its bits sit at the bottom of shift_in
  assign ld_addr     = shift_in[ADDR_W-1:0];
  assign ld_rw       = shift_in[ADDR_W];
  assign ld_in_range = {1'b0, ld_addr} < REGS_LIM;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ld_addr == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      overrun   <= 1'b0;
      out_sh    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (ncs_rise) begin
        state <= ST_IDLE;
        if (state != ST_IDLE) begin
          if (!frame_ok) begin
            frame_err <= 1'b1;
          end else if (fr_rw == RW_WRITE) begin
            if (fr_in_range) begin
              wr_strobe <= 1'b1;
              wr_addr   <= fr_addr;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
      end else if (state == ST_IDLE) begin
        if (!ncs_lvl) begin
          state    <= ST_CMD;
          bit_cnt  <= '0;
          shift_in <= '0;
          overrun  <= 1'b0;
          out_sh   <= '0;
        end
      end else if (sclk_rise) begin
        if (bit_cnt == CNT_FRAME) begin
          overrun <= 1'b1;
        end else begin
          shift_in <= {shift_in[FRAME-2:0], copi_lvl};
          bit_cnt  <= cnt_next;
          if (cnt_next == CNT_FRAME)         state <= ST_DONE;
          else if (cnt_next == CNT_ADDR_END) state <= ST_DATA;
          else if (cnt_next == CNT_ONE)      state <= ST_ADDR;
        end
      end else if (sclk_fall && (state == ST_DATA)) begin
        if (bit_cnt == CNT_ADDR_END) begin
          if (ld_rw == RW_READ) begin
            out_sh <= ld_in_range ? rd_data : '0;
            if (!ld_in_range) frame_err <= 1'b1;
          end
        end else begin
          out_sh <= {out_sh[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (fr_addr == ADDR_W'(i)) regs[i] <= fr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  assign cipo_oe = ~ncs_lvl;
  assign cipo    = (!ncs_lvl && (state == ST_DATA || state == ST_DONE)) ? out_sh[DATA_W-1] : 1'b0;

endmodule
